// File: rtl/if_queue_if.sv
// Fetch-to-decode handshake bundle for if_queue.
// The queue (slave) accepts entries on the in_* side and presents its head on the out_* side.
interface if_queue_if;
  logic        in_valid_i;
  logic [63:0] in_pc_i;
  logic [31:0] in_inst_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [63:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        out_ready_i;

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );
endinterface

// File: rtl/if_queue.sv
// if_queue: instruction-fetch queue between ifetch and id.
// Circular buffer of DEPTH {pc, inst} entries with flush for branch redirect.
// Optional macro IFQ_BYPASS_EN: when the queue is empty an offered entry is
// presented to id combinationally and, if consumed that cycle, never stored.
module if_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  if_queue_if.slave                q,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic            q_vld;
  logic            byp;
  logic            push_q;
  logic            pop_q;
  entry_t          hd;

  assign hd = mem[head];

  // Full check ignores out_ready_i so no push ever lands on a full queue.
  assign q.in_ready_o = (count_o < CW'(DEPTH)) && !reset;

  // Stored head is visible only outside reset and flush.
  assign q_vld = (count_o != '0) && !flush_i && !reset;

`ifdef IFQ_BYPASS_EN
  assign byp = (count_o == '0) && q.in_valid_i && !flush_i && !reset;
`else
  assign byp = 1'b0;
`endif

  assign q.out_valid_o = q_vld || byp;

  // A bypassed entry that id takes in the same cycle is not written.
  assign push_q = q.in_valid_i && q.in_ready_o && !flush_i && !(byp && q.out_ready_i);
  assign pop_q  = q_vld && q.out_ready_i;

  // Head data mux; outputs read zero whenever nothing is valid.
  always_comb begin
    q.out_pc_o   = '0;
    q.out_inst_o = '0;
    if (byp) begin
      q.out_pc_o   = q.in_pc_i;
      q.out_inst_o = q.in_inst_i;
    end else if (q_vld) begin
      q.out_pc_o   = hd.pc;
      q.out_inst_o = hd.inst;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push_q) mem[tail] <= '{pc: q.in_pc_i, inst: q.in_inst_i};
  end

  // Pointers and occupancy; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
    end else begin
      if (push_q) tail <= tail + 1'b1;
      if (pop_q)  head <= head + 1'b1;
      case ({push_q, pop_q})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end
endmodule
